// File: rtl/dvi_video_timing_ctrl.sv
// DVI pixel-clock timing sequencer: counters, syncs, de, pixel request, underflow.
// Optional DVI_TEST_PATTERN_EN adds an 8-bar colour pattern output.
module dvi_video_timing_ctrl #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        pxlclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic        err_clear,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        pix_req,
  output logic        frame_start,
  output logic        line_start,
  output logic        running,
  output logic        underflow,
  output logic [15:0] underflow_cnt
`ifdef DVI_TEST_PATTERN_EN
  ,
  output logic [23:0] pattern_rgb
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_S   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_E   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_S   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_E   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [10:0] h_q, h_d, v_q, v_d;
  logic        frame_end;

  logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        req_q, req_d, fs_q, fs_d, ls_q, ls_d, run_q, run_d;
  logic        uf_q, uf_d;
  logic [15:0] cnt_q, cnt_d;

  assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);

  always_ff @(posedge pxlclk) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)         state_d = RUN;
        else if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (state_q != IDLE) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
        v_d = v_q;
      end
    end
  end

  always_comb begin
    run_d   = (state_q != IDLE);
    de_d    = run_d && (h_q < H_ACT) && (v_q < V_ACT);
    hsync_d = (run_d && h_q >= HS_S && h_q < HS_E) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = (run_d && v_q >= VS_S && v_q < VS_E) ? VSYNC_POL : ~VSYNC_POL;
    x_d     = de_d ? h_q : '0;
    y_d     = de_d ? v_q : '0;
    fs_d    = run_d && (h_q == '0) && (v_q == '0);
    ls_d    = run_d && (h_q == '0);
    // request looks at where the counters will be next cycle
    req_d   = (state_d != IDLE) && (h_d < H_ACT) && (v_d < V_ACT);
    uf_d    = uf_q;
    cnt_d   = cnt_q;
    if (err_clear) begin
      uf_d  = 1'b0;
      cnt_d = '0;
    end else if (de_q && !pix_valid) begin
      uf_d  = 1'b1;
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pxlclk) begin
    if (rst) begin
      de_q    <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      x_q     <= '0;
      y_q     <= '0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      run_q   <= 1'b0;
      uf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      x_q     <= x_d;
      y_q     <= y_d;
      req_q   <= req_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      run_q   <= run_d;
      uf_q    <= uf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign de            = de_q;
  assign x             = x_q;
  assign y             = y_q;
  assign pix_req       = req_q;
  assign frame_start   = fs_q;
  assign line_start    = ls_q;
  assign running       = run_q;
  assign underflow     = uf_q;
  assign underflow_cnt = cnt_q;

`ifdef DVI_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  logic [2:0]  bar;
  logic [23:0] rgb_d, rgb_q;

  always_comb begin
    bar   = 3'(h_q / BAR_W);
    rgb_d = '0;
    if (de_d) begin
      case (bar)
        3'd0:    rgb_d = 24'hFFFFFF;
        3'd1:    rgb_d = 24'hFFFF00;
        3'd2:    rgb_d = 24'h00FFFF;
        3'd3:    rgb_d = 24'h00FF00;
        3'd4:    rgb_d = 24'hFF00FF;
        3'd5:    rgb_d = 24'hFF0000;
        3'd6:    rgb_d = 24'h0000FF;
        default: rgb_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge pxlclk) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= rgb_d;
  end

  assign pattern_rgb = rgb_q;
`endif

endmodule

// File: tb/tb_dvi_video_timing_ctrl.sv
// Scoreboard bench for dvi_video_timing_ctrl on a shrunken raster.
// A frame-position reference model predicts every output cycle.
module tb_dvi_video_timing_ctrl;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pix_valid = 1'b0;
  logic        err_clear = 1'b0;
  logic        hsync, vsync, de, pix_req;
  logic        frame_start, line_start, running, underflow;
  logic [10:0] x, y;
  logic [15:0] underflow_cnt;
`ifdef DVI_TEST_PATTERN_EN
  logic [23:0] pattern_rgb;
`endif

  always #5 clk = ~clk;

  dvi_video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .pxlclk(clk),
    .rst(rst),
    .enable(enable),
    .pix_valid(pix_valid),
    .err_clear(err_clear),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .x(x),
    .y(y),
    .pix_req(pix_req),
    .frame_start(frame_start),
    .line_start(line_start),
    .running(running),
    .underflow(underflow),
    .underflow_cnt(underflow_cnt)
`ifdef DVI_TEST_PATTERN_EN
    ,
    .pattern_rgb(pattern_rgb)
`endif
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        req;
    logic        fs;
    logic        ls;
    logic        run;
    logic        uf;
    logic [15:0] cnt;
    logic [23:0] rgb;
  } obs_t;

  obs_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  logic last_req = 1'b0;

  // reference model: counting flag, drain flag, linear position in frame
  bit   m_active = 0;
  bit   m_drain = 0;
  int   m_pos = 0;
  bit   m_de = 0;
  bit   m_uf = 0;
  int   m_cnt = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_color(int h);
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[h / (HA / 8)];
  endfunction

  task automatic step();
    obs_t e;
    int   h, v, npos;
    bit   nact, ndrain;
    h = m_pos % HT;
    v = m_pos / HT;
    e = '0;
    if (rst) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      m_active = 0; m_drain = 0; m_pos = 0;
      m_de = 0; m_uf = 0; m_cnt = 0;
    end else begin
      e.run = m_active;
      e.de  = m_active && h < HA && v < VA;
      if (e.de) begin
        e.x = 11'(h);
        e.y = 11'(v);
`ifdef DVI_TEST_PATTERN_EN
        e.rgb = bar_color(h);
`endif
      end
      e.hs = !(m_active && h >= HA + HF && h < HA + HF + HS);
      e.vs = !(m_active && v >= VA + VF && v < VA + VF + VS);
      e.fs = m_active && m_pos == 0;
      e.ls = m_active && h == 0;
      if (err_clear) begin
        m_uf = 0; m_cnt = 0;
      end else if (m_de && !pix_valid) begin
        m_uf = 1;
        if (m_cnt < 65535) m_cnt++;
      end
      e.uf  = m_uf;
      e.cnt = 16'(m_cnt);
      if (!m_active) begin
        nact = enable; ndrain = 0; npos = 0;
      end else if (m_drain && !enable && m_pos == FT - 1) begin
        nact = 0; ndrain = 0; npos = 0;
      end else begin
        nact = 1; ndrain = !enable; npos = (m_pos + 1) % FT;
      end
      e.req    = nact && (npos % HT) < HA && (npos / HT) < VA;
      m_de     = e.de;
      m_active = nact;
      m_drain  = ndrain;
      m_pos    = npos;
    end
    q.push_back(e);
    last_req = pix_req;
    @(negedge clk);
  endtask

  task automatic tick();
    pix_valid = last_req;
    step();
  endtask

  initial begin : monitor
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        a = '0;
        a.hs = hsync; a.vs = vsync; a.de = de; a.x = x; a.y = y;
        a.req = pix_req; a.fs = frame_start; a.ls = line_start;
        a.run = running; a.uf = underflow; a.cnt = underflow_cnt;
`ifdef DVI_TEST_PATTERN_EN
        a.rgb = pattern_rgb;
`endif
        check("cycle", 128'(a), 128'(e));
      end
    end
  end

  initial begin : driver
    int k, de_c, hs_c, vs_c, fs_c, ls_c;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    check("rst_running", running, 0);
    check("rst_syncs", {hsync, vsync}, 2'b11);
    check("rst_de_req", {de, pix_req, frame_start, line_start}, 0);
    check("rst_uf", {underflow, underflow_cnt}, 0);
    rst = 1'b0;
    repeat (4) tick();
    check("idle_syncs", {hsync, vsync, running}, 3'b110);

    enable = 1'b1;
    k = 0;
    while (!frame_start && k < 2 * FT) begin tick(); k++; end
    check("first_fs_latency", k, 2);
    de_c = 0; hs_c = 0; vs_c = 0; fs_c = 0; ls_c = 0;
    for (int i = 0; i < FT; i++) begin
      de_c += int'(de); hs_c += int'(!hsync); vs_c += int'(!vsync);
      fs_c += int'(frame_start); ls_c += int'(line_start);
      tick();
    end
    check("fs_period", frame_start, 1);
    check("de_per_frame", de_c, HA * VA);
    check("hsync_per_frame", hs_c, HS * VT);
    check("vsync_per_frame", vs_c, VS * HT);
    check("fs_per_frame", fs_c, 1);
    check("ls_per_frame", ls_c, VT);
    check("tied_no_uf", {underflow, underflow_cnt}, 0);

    k = 0;
    while (!(de && x == 2) && k < 2 * FT) begin tick(); k++; end
    check("uf_sync_found", de && x == 2, 1);
    repeat (5) begin pix_valid = 1'b0; step(); end
    check("uf_cnt5", underflow_cnt, 5);
    check("uf_flag", underflow, 1);
    pix_valid = 1'b0;
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("uf_cleared", {underflow, underflow_cnt}, 0);

    k = 0;
    while (m_pos != 3 * HT && k < 2 * FT) begin tick(); k++; end
    enable = 1'b0;
    k = 0;
    while (running && k < 2 * FT) begin tick(); k++; end
    check("drain_len", k, FT - 3 * HT + 1);
    check("drain_idle", {running, hsync, vsync, de}, 4'b0110);

    enable = 1'b1;
    k = 0;
    while (!frame_start && k < 2 * FT) begin tick(); k++; end
    tick();
    k = 1;
    while (!frame_start && k < 2 * FT) begin
      if (m_pos == 2 * HT) enable = 1'b0;
      if (m_pos == 5 * HT) enable = 1'b1;
      tick();
      k++;
    end
    check("resume_period", k, FT);

`ifdef DVI_TEST_PATTERN_EN
    k = 0;
    while (!(de && x == HA / 8) && k < 2 * FT) begin tick(); k++; end
    check("rgb_yellow", pattern_rgb, 24'hFFFF00);
    k = 0;
    while (!(de && x == HA - 1) && k < 2 * FT) begin tick(); k++; end
    check("rgb_black", pattern_rgb, 24'h000000);
`endif

    for (int i = 0; i < 4 * FT; i++) begin
      pix_valid = ($urandom_range(9) == 0) ? 1'($urandom) : last_req;
      err_clear = ($urandom_range(39) == 0);
      if ($urandom_range(499) == 0) enable = !enable;
      step();
    end
    err_clear = 1'b0;

    enable = 1'b1;
    k = 0;
    while (m_pos != (VA + VF + 1) * HT + HA + HF + 1 && k < 3 * FT) begin
      tick(); k++;
    end
    check("mid_sync", {hsync, vsync, running}, 3'b001);
    rst = 1'b1;
    step();
    check("midrst", {hsync, vsync, de, running}, 4'b1100);
    rst = 1'b0;
    repeat (HT) tick();
    enable = 1'b0;
    repeat (3) tick();
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_video_timing_ctrl.md
Name: dvi_video_timing_ctrl

Overview:
- Pixel-clock-domain sequencer that drives the TMDS encode/serialize path.
- Generates horizontal and vertical counters, de/hsync/vsync, and frame and line markers.
- Runs a one-cycle-ahead pixel request handshake to the pixel source and flags underflow.
- Starts and stops output cleanly on frame boundaries, so the serializer never sees a torn frame.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync asserted level (0 = active low)
VSYNC_POL, 0, vsync asserted level (0 = active low)

Ports:
pxlclk  input  1  pixel clock; sole clock
rst  input  1  synchronous, active-high reset
enable  input  1  request video output
pix_valid  input  1  source has pixel for the current de cycle
err_clear  input  1  clears the underflow flag and count
hsync  output  1  horizontal sync, polarity per HSYNC_POL
vsync  output  1  vertical sync, polarity per VSYNC_POL
de  output  1  data enable (active video)
x  output  11  active pixel column; 0 outside active video
y  output  11  active line; 0 outside active video
pix_req  output  1  asserted one cycle before each de cycle
frame_start  output  1  1-cycle pulse at h=0, v=0 while running
line_start  output  1  1-cycle pulse at h=0 of every line while running
running  output  1  high in RUN and DRAIN
underflow  output  1  sticky: de high while pix_valid low
underflow_cnt  output  16  saturating count of underflow cycles

Behaviour:
- Reset values:
  - state IDLE; h=0, v=0.
  - de, pix_req, frame_start, line_start, running, underflow = 0; underflow_cnt = 0; x = 0, y = 0.
  - hsync = ~HSYNC_POL; vsync = ~VSYNC_POL.
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Counters:
  - h wraps H_TOTAL-1 -> 0; v increments on h wrap and wraps V_TOTAL-1 -> 0.
  - Counters advance only in RUN/DRAIN; held at 0 in IDLE.
- Regions, per counter, in order: active [0, ACTIVE), front porch, sync, back porch.
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for whole lines with v in the corresponding V range.
- Output timing:
  - All outputs are registered; de/hsync/vsync/x/y reflect counter value (h, v) one cycle after the counter holds it.
  - de = (h < H_ACTIVE) && (v < V_ACTIVE); x = h, y = v while de is high.
  - pix_req is high exactly one cycle before each de-high cycle, including the first pixel of each line.
  - pix_req is never issued for lines at v >= V_ACTIVE.
- FSM:
  - IDLE: outputs idle (syncs at deasserted level). IDLE -> RUN when enable = 1; the first cycle in RUN emits frame_start with h=0, v=0.
  - RUN: enable = 0 -> DRAIN. rst -> IDLE.
  - DRAIN: continue timing to the end of the frame (h=H_TOTAL-1, v=V_TOTAL-1), then IDLE.
  - In DRAIN, if enable returns to 1 before the frame end: go back to RUN with no discontinuity in the counters.
- Underflow:
  - On any cycle with de=1 and pix_valid=0: underflow <= 1 and underflow_cnt increments, saturating at 0xFFFF.
  - err_clear has priority over a simultaneous underflow event: the flag and count clear, and that cycle's event is dropped.
- Reset mid-frame: next cycle matches the reset values above; no partial sync pulse is extended.

Optional Feature:
DVI_TEST_PATTERN_EN
- Defined:
  - Adds output pattern_rgb [23:0], registered and aligned with de.
  - Pattern is 8 vertical bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black (0xFFFFFF, 0xFFFF00, 0x00FFFF, 0x00FF00, 0xFF00FF, 0xFF0000, 0x0000FF, 0x000000).
  - pattern_rgb is 0 when de=0.
  - Underflow detection still operates.
- Not defined: the port and its logic are absent; everything else is identical.

Test Plan:
- Reset then enable=1, run one full frame -> exactly 800*525 = 420000 cycles between frame_start pulses; de high for 640*480 = 307200 cycles; each line gives 640 de, 96 hsync-low, 160 blanking cycles.
- Sync placement -> hsync low for h 656..751; vsync low for lines 490..491; x runs 0..639 and y runs 0..479 during de, both 0 otherwise.
- Check pix_req against de over a frame with pix_valid tied to delayed pix_req -> pix_req leads de by exactly 1 cycle every line; underflow stays 0 and underflow_cnt stays 0.
- Hold pix_valid=0 for 5 de cycles, then pulse err_clear coincident with a sixth underflow -> underflow_cnt reads 5 before the clear; flag and count read 0 after it.
- Drop enable at line 100, then leave it low -> running stays 1 until end of frame (h=799, v=524), then IDLE with syncs deasserted. Repeat but raise enable at line 300 -> counters continue uninterrupted.
- Assert rst at h=700, v=491 (mid hsync and vsync) -> next cycle hsync=vsync=1, de=0, running=0; with DVI_TEST_PATTERN_EN, pattern_rgb = 0xFFFF00 at x=80 and 0x000000 at x=639.
